// File: rtl/pdm_tx_pkg.sv
// Shared constants and helpers for the pdm_tx PDM transmitter.
// PDM_TX_SECOND_ORDER_EN widens the modulator accumulators for the second-order loop.
package pdm_tx_pkg;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } pdm_phase_e;

  // Full-scale feedback magnitude for a signed sample of the given width.
  function automatic int fs_of(input int width);
    return 1 << (width - 1);
  endfunction

  function automatic int acc_width(input int width);
`ifdef PDM_TX_SECOND_ORDER_EN
    return width + 4;
`else
    return width + 2;
`endif
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pdm_tx_sdm.sv
// One sigma-delta modulator channel: emits the current bit, advances on i_step.
// PDM_TX_SECOND_ORDER_EN selects a saturating second-order loop instead of first-order.
module pdm_tx_sdm
  import pdm_tx_pkg::*;
#(
  parameter int P_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic [P_WIDTH-1:0] i_sample,
  output logic               o_bit
);

  localparam int ACC_W = acc_width(P_WIDTH);
  localparam logic signed [ACC_W-1:0] FS = ACC_W'(fs_of(P_WIDTH));

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] fb;
  logic signed [ACC_W-1:0] s1_q, s1_d;

  assign x_ext = {{(ACC_W - P_WIDTH){i_sample[P_WIDTH-1]}}, i_sample};

`ifdef PDM_TX_SECOND_ORDER_EN
  logic signed [ACC_W-1:0] s2_q, s2_d;
  logic signed [31:0] s1_w, s2_w, x_w, fb_w;
  logic signed [31:0] s1_sum, s1_sat, s2_sum, s2_sat;

  // Sums are formed at 32 bits and clamped back to the accumulator range.
  always_comb begin
    o_bit  = ~s2_q[ACC_W-1];
    fb     = o_bit ? FS : -FS;
    s1_w   = {{(32 - ACC_W){s1_q[ACC_W-1]}}, s1_q};
    s2_w   = {{(32 - ACC_W){s2_q[ACC_W-1]}}, s2_q};
    x_w    = {{(32 - ACC_W){x_ext[ACC_W-1]}}, x_ext};
    fb_w   = {{(32 - ACC_W){fb[ACC_W-1]}}, fb};
    s1_sum = s1_w + x_w - fb_w;
    s1_sat = saturate(s1_sum, ACC_W);
    s2_sum = s2_w + s1_sat - fb_w;
    s2_sat = saturate(s2_sum, ACC_W);
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (i_step) begin
      s1_d = s1_sat[ACC_W-1:0];
      s2_d = s2_sat[ACC_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
`else
  // Two guard bits keep s within [-2FS, 2FS) for any input sequence.
  always_comb begin
    o_bit = ~s1_q[ACC_W-1];
    fb    = o_bit ? FS : -FS;
    s1_d  = s1_q;
    if (i_step) s1_d = s1_q + x_ext - fb;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) s1_q <= '0;
    else         s1_q <= s1_d;
  end
`endif

endmodule

// File: rtl/pdm_tx.sv
// Stereo PDM transmitter: double-buffered sample pairs, divided bit clock, two modulators.
// Define PDM_TX_SECOND_ORDER_EN for second-order modulators (first-order otherwise).
module pdm_tx
  import pdm_tx_pkg::*;
#(
  parameter int P_WIDTH = 8,
  parameter int P_DIV   = 2,
  parameter int P_OSR   = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_dataR,
  input  logic [P_WIDTH-1:0] i_dataF,
  output logic               o_pdm_clk,
  output logic               o_pdm_data,
  output logic               o_frame,
  output logic               o_underrun
);

  localparam int DIV_W = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam int OSR_W = $clog2(P_OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(P_OSR - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  pdm_phase_e         phase_q, phase_d;
  logic [OSR_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic               pdm_data_q, pdm_data_d;
  logic               frame_q, frame_d;
  logic               underrun_q, underrun_d;
  logic               shadow_full_q, shadow_full_d;
  logic [P_WIDTH-1:0] shadow_r_q, shadow_r_d;
  logic [P_WIDTH-1:0] shadow_f_q, shadow_f_d;
  logic [P_WIDTH-1:0] active_r_q, active_r_d;
  logic [P_WIDTH-1:0] active_f_q, active_f_d;

  logic wrap, rise_tog, fall_tog, boundary, xfer;
  logic r_bit, f_bit;

  always_comb begin
    wrap     = (div_q == DIV_LAST);
    rise_tog = wrap && (phase_q == PH_LOW);
    fall_tog = wrap && (phase_q == PH_HIGH);
    boundary = rise_tog && (frm_cnt_q == OSR_LAST);
    xfer     = i_valid && !shadow_full_q;
  end

  always_comb begin
    div_d = wrap ? '0 : div_q + DIV_W'(1);

    phase_d = phase_q;
    if (wrap) phase_d = (phase_q == PH_LOW) ? PH_HIGH : PH_LOW;

    frm_cnt_d = frm_cnt_q;
    if (rise_tog) frm_cnt_d = boundary ? '0 : frm_cnt_q + OSR_W'(1);

    // R bit is shown while the clock is low, F bit while it is high.
    pdm_data_d = pdm_data_q;
    if (fall_tog)      pdm_data_d = r_bit;
    else if (rise_tog) pdm_data_d = f_bit;

    frame_d    = boundary;
    underrun_d = boundary && !shadow_full_q;

    active_r_d    = active_r_q;
    active_f_d    = active_f_q;
    shadow_r_d    = shadow_r_q;
    shadow_f_d    = shadow_f_q;
    shadow_full_d = shadow_full_q;
    if (boundary && shadow_full_q) begin
      active_r_d    = shadow_r_q;
      active_f_d    = shadow_f_q;
      shadow_r_d    = '0;
      shadow_f_d    = '0;
      shadow_full_d = 1'b0;
    end
    // A push on an empty-shadow boundary cycle still lands; the underrun stands.
    if (xfer) begin
      shadow_r_d    = i_dataR;
      shadow_f_d    = i_dataF;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q         <= '0;
      phase_q       <= PH_LOW;
      frm_cnt_q     <= '0;
      pdm_data_q    <= 1'b0;
      frame_q       <= 1'b0;
      underrun_q    <= 1'b0;
      shadow_full_q <= 1'b0;
      shadow_r_q    <= '0;
      shadow_f_q    <= '0;
      active_r_q    <= '0;
      active_f_q    <= '0;
    end else begin
      div_q         <= div_d;
      phase_q       <= phase_d;
      frm_cnt_q     <= frm_cnt_d;
      pdm_data_q    <= pdm_data_d;
      frame_q       <= frame_d;
      underrun_q    <= underrun_d;
      shadow_full_q <= shadow_full_d;
      shadow_r_q    <= shadow_r_d;
      shadow_f_q    <= shadow_f_d;
      active_r_q    <= active_r_d;
      active_f_q    <= active_f_d;
    end
  end

  pdm_tx_sdm #(.P_WIDTH(P_WIDTH)) u_sdm_r (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (fall_tog),
    .i_sample (active_r_q),
    .o_bit    (r_bit)
  );

  pdm_tx_sdm #(.P_WIDTH(P_WIDTH)) u_sdm_f (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (rise_tog),
    .i_sample (active_f_q),
    .o_bit    (f_bit)
  );

  assign o_pdm_clk  = (phase_q == PH_HIGH);
  assign o_pdm_data = pdm_data_q;
  assign o_frame    = frame_q;
  assign o_underrun = underrun_q;
  assign o_ready    = !shadow_full_q;

endmodule
